// File: rtl/shift_add_mul_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_mul_scheduler
//  Description : One sequential shift-and-add multiplier shared by REQ
//                requesters. A round-robin arbiter selects a requester, the
//                core consumes one multiplier bit per clock, and the tagged
//                product is returned on a single backpressured channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mul_scheduler #(
    parameter int M   = 8,   // multiplicand width
    parameter int N   = 8,   // multiplier width, also number of RUN cycles
    parameter int REQ = 4,   // number of requesters (power of two)
    parameter int IDW = 2    // log2(REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REQ-1:0]     req_valid,
    input  logic [REQ*M-1:0]   req_a,
    input  logic [REQ*N-1:0]   req_b,
    output logic [REQ-1:0]     req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [M+N-1:0]     rsp_c,
    output logic [IDW-1:0]     rsp_id,
    output logic               busy
);

    // Counter is sized with one spare bit so N = 1 still gets a legal width.
    localparam int             c_CW       = $clog2(N + 1);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(N - 1);
    localparam logic [REQ-1:0] c_ONE_HOT0 = REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic [IDW-1:0]    rr_ptr_q,    rr_ptr_d;
    logic [M+N-1:0]    a_q,         a_d;
    logic [N-1:0]      b_q,         b_d;
    logic [M+N-1:0]    acc_q,       acc_d;
    logic [c_CW-1:0]   cnt_q,       cnt_d;
    logic [M+N-1:0]    rsp_c_q,     rsp_c_d;
    logic [IDW-1:0]    rsp_id_q,    rsp_id_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic              w_grant_found;
    logic [IDW-1:0]    w_grant_idx;
    logic [IDW-1:0]    w_cand;
    logic [M+N-1:0]    w_acc_next;
    logic [REQ-1:0]    w_req_ready;

    // Round-robin search starting at rr_ptr; index arithmetic wraps because
    // REQ is a power of two and the pointer is exactly IDW bits wide.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_cand        = '0;
        for (int k = 0; k < REQ; k++) begin
            w_cand = rr_ptr_q + IDW'(k);
            if (!w_grant_found && req_valid[w_cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
    end

    // Next-state, datapath update and grant output for the IDLE/RUN/DONE FSM.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        rsp_c_d     = rsp_c_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        w_req_ready = '0;
        // Conditional add of the current shifted multiplicand; the product
        // fits in M+N bits so no carry out is ever lost.
        w_acc_next  = b_q[0] ? (acc_q + a_q) : acc_q;

        case (state_q)
            ST_IDLE: begin
                if (w_grant_found) begin
                    // The granted requester is known valid, so this is the handshake.
                    w_req_ready = c_ONE_HOT0 << w_grant_idx;
                    a_d         = {{N{1'b0}}, req_a[w_grant_idx*M +: M]};
                    b_d         = req_b[w_grant_idx*N +: N];
                    acc_d       = '0;
                    cnt_d       = '0;
                    rsp_id_d    = w_grant_idx;
                    rr_ptr_d    = w_grant_idx + IDW'(1);
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = w_acc_next;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + c_CW'(1);
                // Fixed N-cycle latency: no early exit when B runs out of ones.
                if (cnt_q == c_CNT_LAST) begin
                    rsp_c_d     = w_acc_next;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                // Hold the response until the sink takes it; the grant
                // reopens only on the following cycle.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            rsp_c_q     <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            rsp_c_q     <= rsp_c_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mul_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_add_mul_scheduler
//  Description : Self-checking bench for shift_add_mul_scheduler. Directed
//                scenarios followed by randomized traffic, all compared
//                against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_mul_scheduler;

    localparam int M   = 8;
    localparam int N   = 8;
    localparam int REQ = 4;
    localparam int IDW = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [REQ-1:0]     req_valid;
    logic [REQ*M-1:0]   req_a;
    logic [REQ*N-1:0]   req_b;
    logic [REQ-1:0]     req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [M+N-1:0]     rsp_c;
    logic [IDW-1:0]     rsp_id;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    logic [M-1:0] op_a [REQ];
    logic [N-1:0] op_b [REQ];

    // Reference model: m_left is 0 when idle, counts remaining multiply
    // cycles while computing, and is -1 while a response is being held.
    int   m_left;
    int   m_ptr;
    int   m_id;
    int   m_pend;
    int   m_c;
    logic m_valid;

    int   got_id [$];
    int   got_c  [$];
    int   lat;

    shift_add_mul_scheduler #(.M(M), .N(N), .REQ(REQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_c     (rsp_c),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_left  = 0;
        m_ptr   = 0;
        m_id    = 0;
        m_pend  = 0;
        m_c     = 0;
        m_valid = 1'b0;
    endtask

    // First valid requester at or after the pointer, modulo REQ.
    function automatic int model_grant();
        if (m_left != 0) return -1;
        for (int k = 0; k < REQ; k++) begin
            if (req_valid[(m_ptr + k) % REQ]) return (m_ptr + k) % REQ;
        end
        return -1;
    endfunction

    task automatic pack_ops();
        for (int i = 0; i < REQ; i++) begin
            req_a[i*M +: M] = op_a[i];
            req_b[i*N +: N] = op_b[i];
        end
    endtask

    task automatic check_outputs();
        check_eq("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        check_eq("rsp_c",     32'(rsp_c),     32'(m_c));
        check_eq("rsp_id",    32'(rsp_id),    32'(m_id));
        check_eq("busy",      32'(busy),      32'(m_left != 0));
    endtask

    // One clock: check the combinational grant, advance the model across
    // the edge, then check registered outputs just after it.
    task automatic cycle();
        int             g;
        logic [REQ-1:0] exp_rdy;
        pack_ops();
        #1;
        g       = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (m_left == 0) begin
            if (g >= 0) begin
                m_pend = int'(op_a[g]) * int'(op_b[g]);
                m_id   = g;
                m_ptr  = (g + 1) % REQ;
                m_left = N;
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_valid = 1'b1;
                m_c     = m_pend;
                m_left  = -1;
            end
        end else if (rsp_ready) begin
            m_valid = 1'b0;
            m_left  = 0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic issue(input int r, input int a, input int b);
        op_a[r]   = M'(a);
        op_b[r]   = N'(b);
        req_valid = '0;
        req_valid[r] = 1'b1;
        cycle();
        req_valid = '0;
    endtask

    task automatic wait_rsp(output int l);
        l = 0;
        while (!rsp_valid && l < 40) begin
            cycle();
            l++;
        end
        if (!rsp_valid) check_eq("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 40 && m_left != 0; i++) cycle();
        check_eq("drain_idle", 32'(busy), 32'd0);
    endtask

    task automatic single(input string tag, input int r, input int a, input int b, input int exp_c);
        issue(r, a, b);
        wait_rsp(lat);
        check_eq({tag, "_lat"}, 32'(lat), 32'(N));
        check_eq({tag, "_c"},   32'(rsp_c), 32'(exp_c));
        check_eq({tag, "_id"},  32'(rsp_id), 32'(r));
        cycle();
    endtask

    initial begin
        model_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < REQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        pack_ops();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        check_eq("reset_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single request and operand extremes; pointer ends at 0.
        single("mul13x11", 0, 13, 11, 143);
        single("mul255sq", 2, 255, 255, 65025);
        single("mul0x200", 3, 0, 200, 0);
        single("mul9x0",   3, 9, 0, 0);

        // Round robin with all requesters continuously valid.
        for (int i = 0; i < REQ; i++) begin
            op_a[i] = M'(i + 1);
            op_b[i] = N'(10);
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        got_id.delete();
        got_c.delete();
        for (int i = 0; i < 100 && got_id.size() < 5; i++) begin
            cycle();
            if (rsp_valid) begin
                got_id.push_back(int'(rsp_id));
                got_c.push_back(int'(rsp_c));
            end
        end
        check_eq("rr_count", 32'(got_id.size()), 32'd5);
        for (int i = 0; i < got_id.size(); i++) begin
            check_eq("rr_order", 32'(got_id[i]), 32'(i % REQ));
            check_eq("rr_prod",  32'(got_c[i]),  32'(((i % REQ) + 1) * 10));
        end
        drain();

        // Backpressure: response held stable, no grants while held.
        rsp_ready = 1'b0;
        issue(1, 5, 6);
        wait_rsp(lat);
        req_valid = '1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("bp_valid", 32'(rsp_valid), 32'd1);
            check_eq("bp_c",     32'(rsp_c),     32'd30);
            check_eq("bp_id",    32'(rsp_id),    32'd1);
            check_eq("bp_noack", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        cycle();
        check_eq("bp_release", 32'(rsp_valid), 32'd0);
        cycle();
        check_eq("bp_regrant", 32'(busy), 32'd1);
        drain();

        // Reset in the 4th RUN cycle discards the operation.
        issue(2, 100, 100);
        repeat (3) cycle();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) cycle();
        op_a[1] = M'(7);
        op_b[1] = N'(6);
        op_a[3] = M'(50);
        op_b[3] = N'(3);
        req_valid = 4'b1010;
        pack_ops();
        #1;
        check_eq("post_rst_grant", 32'(req_ready), 32'b0010);
        cycle();
        req_valid = '0;
        wait_rsp(lat);
        check_eq("post_rst_c",  32'(rsp_c),  32'd42);
        check_eq("post_rst_id", 32'(rsp_id), 32'd1);
        drain();

        // Requester 3 withdraws while the block is busy.
        for (int i = 0; i < REQ; i++) begin
            op_a[i] = M'(i + 1);
            op_b[i] = N'(10);
        end
        req_valid = '1;
        cycle();
        req_valid = 4'b0111;
        got_id.delete();
        for (int i = 0; i < 100 && got_id.size() < 4; i++) begin
            cycle();
            if (rsp_valid) begin
                got_id.push_back(int'(rsp_id));
                check_eq("wd_prod", 32'(rsp_c), 32'((int'(rsp_id) + 1) * 10));
            end
        end
        check_eq("wd_count", 32'(got_id.size()), 32'd4);
        for (int i = 0; i < got_id.size(); i++) check_eq("wd_no3", 32'(got_id[i] == 3), 32'd0);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            req_valid = REQ'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < REQ; r++) begin
                case ($urandom_range(0, 5))
                    0:       op_a[r] = '0;
                    1:       op_a[r] = '1;
                    default: op_a[r] = M'($urandom);
                endcase
                case ($urandom_range(0, 5))
                    0:       op_b[r] = '0;
                    1:       op_b[r] = '1;
                    default: op_b[r] = N'($urandom);
                endcase
            end
            cycle();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
